// File: rtl/axis_fifo_2048_pkg.sv
// Shared types and defaults for the 2048-deep AXI-Stream FIFO and its counter source.
package axis_fifo_2048_pkg;

  localparam int DefaultDataWidth = 32;
  localparam int DefaultDepth     = 2048;
  localparam int PtrWidth         = $clog2(DefaultDepth);

  // One stored beat: the frame-end flag travels alongside its payload.
  typedef struct packed {
    logic                        last;
    logic [DefaultDataWidth-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/axis_fifo_2048_counter_up.sv
// Framed up-counter traffic source: emits 0..count_up_to-1 repeatedly, last on the final value.
module counter_up
  import axis_fifo_2048_pkg::*;
#(
  parameter int DataWidth = DefaultDataWidth
) (
  input  logic                 counter_clk,
  input  logic                 reset,
  input  logic [DataWidth-1:0] count_up_to,
  output logic [DataWidth-1:0] count_up,
  output logic                 count_valid,
  output logic                 count_last,
  input  logic                 count_ready
);

  logic [DataWidth-1:0] count_q, count_d;
  logic                 valid_q;
  logic                 at_end;

  assign at_end = (count_q == count_up_to - 1'b1);

  always_comb begin
    count_d = count_q;
    if (valid_q && count_ready) begin
      count_d = at_end ? '0 : count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge counter_clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= (count_up_to != '0);
    end
  end

  assign count_up    = count_q;
  assign count_valid = valid_q;
  assign count_last  = valid_q && at_end;

endmodule

// File: rtl/axis_fifo_2048.sv
// Synchronous first-word-fall-through AXI-Stream FIFO storing {last, data} per entry.
module axis_fifo_2048
  import axis_fifo_2048_pkg::*;
#(
  parameter int DataWidth = DefaultDataWidth,
  parameter int Depth     = DefaultDepth
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DataWidth-1:0] writeData,
  input  logic                 writeDataValid,
  output logic                 writeDataReady,
  input  logic                 writeDataLast,
  output logic [DataWidth-1:0] readData,
  output logic                 readDataValid,
  input  logic                 readDataReady,
  output logic                 readDataLast
);

  localparam int AddrWidth = $clog2(Depth);
  localparam logic [AddrWidth:0] FullCount = (AddrWidth + 1)'(Depth);

  fifo_entry_t           mem [Depth];
  fifo_entry_t           head;
  logic [AddrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AddrWidth:0]    count_q, count_d;
  logic                  wr_hs, rd_hs;

  assign writeDataReady = (count_q != FullCount);
  assign readDataValid  = (count_q != '0);

  assign wr_hs = writeDataValid && writeDataReady;
  assign rd_hs = readDataValid && readDataReady;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    unique case ({wr_hs, rd_hs})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_hs) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_hs) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; stale entries are unreachable once the pointers and count clear.
  always_ff @(posedge clk) begin
    if (wr_hs) begin
      mem[wr_ptr_q] <= '{last: writeDataLast, data: writeData};
    end
  end

  assign head         = mem[rd_ptr_q];
  assign readData     = head.data;
  assign readDataLast = head.last;

endmodule

// File: tb/tb_axis_fifo_2048.sv
// Directed bench: counter_up feeds the FIFO; a scoreboard queue checks order, flags and framing.
module tb_axis_fifo_2048;

  localparam int DW    = 32;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] wr_data, dir_data, rd_data;
  logic          wr_valid, wr_last, wr_ready, dir_valid, dir_last;
  logic          rd_valid, rd_ready, rd_last;
  logic          use_cnt;
  logic [DW-1:0] cnt_up, cnt_up_to;
  logic          cnt_valid, cnt_last, cnt_ready;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int rd_count = 0;
  logic [DW:0] sb [$];

  always #5 clk = ~clk;

  assign wr_data   = use_cnt ? cnt_up    : dir_data;
  assign wr_valid  = use_cnt ? cnt_valid : dir_valid;
  assign wr_last   = use_cnt ? cnt_last  : dir_last;
  assign cnt_ready = use_cnt && wr_ready;

  counter_up #(.DataWidth(DW)) u_src (
    .counter_clk (clk),
    .reset       (reset),
    .count_up_to (cnt_up_to),
    .count_up    (cnt_up),
    .count_valid (cnt_valid),
    .count_last  (cnt_last),
    .count_ready (cnt_ready)
  );

  axis_fifo_2048 #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .writeData      (wr_data),
    .writeDataValid (wr_valid),
    .writeDataReady (wr_ready),
    .writeDataLast  (wr_last),
    .readData       (rd_data),
    .readDataValid  (rd_valid),
    .readDataReady  (rd_ready),
    .readDataLast   (rd_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: flags against model occupancy, then retire/enqueue the handshakes of the coming edge.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      chk("rst_wr_ready", 64'(wr_ready), 64'd1);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    end else begin
      chk("wr_ready", 64'(wr_ready), 64'(sb.size() != DEPTH));
      chk("rd_valid", 64'(rd_valid), 64'(sb.size() != 0));
      if (rd_valid && rd_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) chk("rd_beat", 64'({rd_last, rd_data}), 64'(sb.pop_front()));
        rd_count++;
      end
      if (wr_valid && wr_ready) begin
        sb.push_back({wr_last, wr_data});
        wr_count++;
      end
    end
  end

  initial begin
    int w0;
    int r0;
    int waited;

    reset = 1'b0; dir_valid = 1'b0; dir_data = '0; dir_last = 1'b0;
    rd_ready = 1'b0; use_cnt = 1'b0; cnt_up_to = 32'd16;

    // Reset state
    @(posedge clk); #1;
    chk("rst_cnt_up", 64'(cnt_up), 64'd0);
    chk("rst_cnt_valid", 64'(cnt_valid), 64'd0);
    chk("rst_cnt_last", 64'(cnt_last), 64'd0);
    chk("rst_out_ready", 64'(wr_ready), 64'd1);
    chk("rst_out_valid", 64'(rd_valid), 64'd0);
    reset = 1'b1;

    // Single beat with fall-through read
    @(posedge clk); #1;
    dir_data = 32'hABCDEFFF; dir_last = 1'b1; dir_valid = 1'b1;
    @(posedge clk); #1;
    dir_valid = 1'b0; dir_last = 1'b0;
    chk("single_valid", 64'(rd_valid), 64'd1);
    chk("single_data", 64'(rd_data), 64'hABCDEFFF);
    chk("single_last", 64'(rd_last), 64'd1);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    chk("single_empty", 64'(rd_valid), 64'd0);
    chk("single_reads", 64'(rd_count), 64'd1);

    // Fill from the counter with the consumer stalled
    w0 = wr_count;
    use_cnt = 1'b1;
    repeat (2800) @(posedge clk);
    #1;
    chk("fill_accepted", 64'(wr_count - w0), 64'd2048);
    chk("fill_ready", 64'(wr_ready), 64'd0);
    chk("fill_cnt_up", 64'(cnt_up), 64'd0);
    chk("fill_cnt_valid", 64'(cnt_valid), 64'd1);

    // Full with one read: write refused that cycle, ready returns after the edge
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    chk("full_rd_ready", 64'(wr_ready), 64'd1);
    chk("full_rd_valid", 64'(rd_valid), 64'd1);

    // Sustained drain with concurrent refill
    r0 = rd_count;
    rd_ready = 1'b1;
    repeat (4800) @(posedge clk);
    #1;
    chk("drain_reads", 64'(rd_count - r0), 64'd4800);

    // Empty the FIFO, then load exactly 1000 beats
    use_cnt = 1'b0;
    waited = 0;
    while (rd_valid && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("drained_empty", 64'(rd_valid), 64'd0);
    rd_ready = 1'b0;
    use_cnt = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    chk("load_1000", 64'(sb.size()), 64'd1000);
    chk("load_valid", 64'(rd_valid), 64'd1);

    // Mid-stream reset
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(wr_ready), 64'd1);
    chk("mid_rst_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_cnt_valid", 64'(cnt_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    rd_ready = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!rd_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("post_rst_valid", 64'(rd_valid), 64'd1);
    chk("post_rst_first", 64'(rd_data), 64'd0);
    repeat (40) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_fifo_2048.md
# axis_fifo_2048

Synchronous 2048-deep AXI-Stream FIFO, 32-bit data plus TLAST, with a companion framed up-counter source (`counter_up`) that feeds it. It decouples a producer that streams continuously from a consumer that may stall for thousands of cycles. Data and the last flag pass through unchanged and in order.

## Interface
Parameters:
- DataWidth, 32, payload width in bits.
- Depth, 2048, number of entries; must be a power of two.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  reset; asynchronous, active-low.
- writeData  in  DataWidth  write payload.
- writeDataValid  in  1  write beat valid.
- writeDataReady  out  1  FIFO can accept a beat.
- writeDataLast  in  1  last beat of frame; stored with the data.
- readData  out  DataWidth  head-of-FIFO payload.
- readDataValid  out  1  head entry present.
- readDataReady  in  1  consumer accepts head.
- readDataLast  out  1  last flag of head entry.

## Operation
- Storage: Depth x (DataWidth+1) array holding {last, data}.
- Write pointer and read pointer are each log2(Depth) bits (11 bits) and wrap naturally. The occupancy count is log2(Depth)+1 bits (12 bits).
- Write handshake is writeDataValid && writeDataReady.
  - On a handshake, store {writeDataLast, writeData} at the write pointer and increment the write pointer.
- Read handshake is readDataValid && readDataReady.
  - On a handshake, increment the read pointer.
- The read side is first-word-fall-through: readData and readDataLast always show mem[read pointer], read asynchronously. Their values are don't-care while readDataValid = 0.
- writeDataReady = (count != Depth). readDataValid = (count != 0). Both are decoded from the registered count.
- Count update: +1 on a write handshake only, -1 on a read handshake only, unchanged when both or neither occur.
- Full: writeDataReady = 0. A write is refused even when a read happens in the same cycle. There is no fall-through of a write while full.
- Empty: readDataValid = 0, so no read is possible. No bypass of a same-cycle write.
- Reset (asserted at any time, including mid-stream): both pointers and count go to 0. writeDataReady becomes 1 and readDataValid becomes 0 immediately. Memory contents are not cleared.

## Timing
- Write to read latency: a beat written at edge N into an empty FIFO gives readDataValid = 1 after edge N (visible in cycle N+1).
- Sustained throughput: one beat per cycle in each direction simultaneously.
- readDataValid rises one cycle after a write into an empty FIFO.
- writeDataReady falls one cycle after the write that fills the FIFO, and rises one cycle after the first read from a full FIFO.
- All outputs are glitch-free registered decodes, except readData and readDataLast, which are combinational from the registered read pointer.

## Structure
- Shared package: DataWidth default, Depth default, the derived pointer width (localparam PtrWidth = $clog2(Depth)), and the {last, data} entry struct type.
- Sub-module `counter_up` is the traffic source, with parameter DataWidth. Its ports are:
  - counter_clk (clock).
  - reset (asynchronous, active-low).
  - count_up_to[DataWidth-1:0].
  - count_up, count_valid, count_last (outputs).
  - count_ready (input).
- counter_up behaviour:
  - In reset: count_up = 0, count_valid = 0, count_last = 0.
  - From the first edge after reset release, count_valid = 1 continuously.
  - It emits 0, 1, …, count_up_to-1, advancing only on count_valid && count_ready.
  - count_last = 1 while count_up == count_up_to-1. After that beat transfers, count_up wraps to 0 and framing repeats indefinitely.
  - If count_up_to == 0, count_valid is held at 0.

## Test plan
- Reset check: hold reset = 0 for 1 cycle, then release -> writeDataReady = 1, readDataValid = 0, and count_up = 0 during reset.
- Single beat: write 0xABCDEFFF with last = 1 into an empty FIFO -> next cycle readDataValid = 1, readData = 0xABCDEFFF, readDataLast = 1. After readDataReady = 1 for one cycle -> readDataValid = 0.
- Fill with counter_up (count_up_to = 16), readDataReady = 0 for 2800 cycles:
  - After exactly 2048 accepted beats, writeDataReady = 0.
  - count_up holds at 0 (2048 mod 16) with count_valid = 1.
- Drain: readDataReady = 1 for 4800 cycles -> read sequence 0..15 repeating with readDataLast = 1 on every value 15.
  - The FIFO stays non-empty with continuous one-beat-per-cycle flow, and no value is skipped or duplicated.
- Full with simultaneous read: at count = 2048, assert readDataReady for 1 cycle -> count becomes 2047, and writeDataReady = 1 the next cycle.
- Mid-stream reset: assert reset with count = 1000 -> readDataValid = 0 and writeDataReady = 1 immediately. After release, the first beat read is counter value 0.
